// File: rtl/sw_debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// Holds the FSM state type and the synchronizer depth.
package sw_debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sw_debounce_sync.sv
// W-bit multi-flop synchronizer for raw switch inputs.
// Instantiated by sw_debounce only when SW_DEBOUNCE_SYNC_EN is defined.
module sw_sync
  import sw_debounce_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [SYNC_STAGES-1:0][W-1:0] r_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= {r_pipe[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/sw_debounce.sv
// Vector switch debouncer: a change must hold for 2^N cycles.
// Optional input synchronizer enabled by macro SW_DEBOUNCE_SYNC_EN.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int N = 20,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  output logic [W-1:0] db_sw,
  output logic         db_tick,
  output logic         busy
);

  localparam logic [N-1:0] ONE = 1;

  logic [W-1:0] w_sw_s;

`ifdef SW_DEBOUNCE_SYNC_EN
  sw_sync #(
    .W(W)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (sw),
    .o_q  (w_sw_s)
  );
`else
  assign w_sw_s = sw;
`endif

  state_t       r_state;
  state_t       w_state_nx;
  logic [N-1:0] r_cnt;
  logic [N-1:0] w_cnt_nx;
  logic [W-1:0] r_cand;
  logic [W-1:0] w_cand_nx;
  logic [W-1:0] r_db;
  logic [W-1:0] w_db_nx;
  logic         r_tick;
  logic         w_tick_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= STABLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_db    <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_cand  <= w_cand_nx;
      r_db    <= w_db_nx;
      r_tick  <= w_tick_nx;
    end
  end

  // Bounce-back beats candidate change, which beats commit.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_cand_nx  = r_cand;
    w_db_nx    = r_db;
    w_tick_nx  = 1'b0;
    unique case (r_state)
      STABLE: begin
        if (w_sw_s != r_db) begin
          w_cand_nx  = w_sw_s;
          w_cnt_nx   = '1;
          w_state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (w_sw_s == r_db) begin
          w_state_nx = STABLE;
        end else if (w_sw_s != r_cand) begin
          w_cand_nx = w_sw_s;
          w_cnt_nx  = '1;
        end else if (r_cnt == '0) begin
          w_db_nx    = r_cand;
          w_tick_nx  = 1'b1;
          w_state_nx = STABLE;
        end else begin
          w_cnt_nx = r_cnt - ONE;
        end
      end
      default: begin
        w_state_nx = STABLE;
      end
    endcase
  end

  assign db_sw   = r_db;
  assign db_tick = r_tick;
  assign busy    = (r_state == SETTLE);

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter: N, default 20, counter width; settle time T = 2^N clock cycles (10.5 ms at 100 MHz).
REQ-002 Parameter: W, default 8, number of switch bits.
REQ-003 Port: clk  input  1  system clock; single clock domain, all flops on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: sw  input  W  raw board switches, asynchronous to clk, may bounce.
REQ-006 Port: db_sw  output  W  debounced switch vector; feeds the adder/display test top in place of raw sw.
REQ-007 Port: db_tick  output  1  one-cycle pulse when db_sw updates.
REQ-008 Port: busy  output  1  high while a candidate value is settling.

Function
REQ-009 The internal sampled input sw_s SHALL be sw after the synchronizer of REQ-020, or sw itself when that synchronizer is compiled out.
REQ-010 FSM states: STABLE, SETTLE; busy SHALL be 1 exactly when the state is SETTLE.
REQ-011 In STABLE with sw_s == db_sw: hold; with sw_s != db_sw: cand <= sw_s, cnt <= 2^N-1, go to SETTLE.
REQ-012 In SETTLE, first priority: if sw_s == db_sw (bounced back), go to STABLE with no db_tick and db_sw unchanged.
REQ-013 In SETTLE, second priority: if sw_s != cand, set cand <= sw_s and reload cnt <= 2^N-1, staying in SETTLE.
REQ-014 In SETTLE, third priority: if cnt == 0, set db_sw <= cand and db_tick <= 1 for one cycle, and go to STABLE.
REQ-015 Otherwise in SETTLE, cnt SHALL decrement by 1; cnt never wraps below 0.
REQ-016 Latency: db_sw SHALL update exactly 2^N clock edges after the STABLE-state edge that detects the change; with the synchronizer, 2^N+2 edges after the first edge sampling the new sw.
REQ-017 All W bits SHALL be debounced as one vector; any bit change restarts settling for the whole vector.
REQ-018 db_tick SHALL never be asserted on two consecutive cycles.

Reset
REQ-019 While reset is high: state = STABLE, cnt = 0, cand = 0, synchronizer flops = 0, db_sw = 0, db_tick = 0, busy = 0. Asserting reset mid-SETTLE SHALL abort the settle with no db_tick, and the first edge after release SHALL behave as STABLE.

Configuration
REQ-020 Macro SW_DEBOUNCE_SYNC_EN: when defined, sw passes through a 2-flop synchronizer (reset to 0) before the FSM; when undefined, the FSM samples sw directly and latency drops by 2 edges. All other behaviour is identical.

Structure
REQ-021 Shared package sw_debounce_pkg SHALL hold the FSM state type (STABLE, SETTLE) and the constant SYNC_STAGES = 2.
REQ-022 One sub-module, sw_sync (W-bit 2-flop synchronizer), SHALL be instantiated only under SW_DEBOUNCE_SYNC_EN.
REQ-023 The counter SHALL be exactly N bits; there SHALL be no other arithmetic.

Verification (N=4, T=16, SW_DEBOUNCE_SYNC_EN defined unless noted)
REQ-024 Reset: assert reset with sw=8'hA5 -> db_sw=8'h00, busy=0, db_tick=0; release with sw held at 8'hA5 -> db_sw=8'hA5 and a single db_tick 18 edges later.
REQ-025 Clean change: sw 8'h00->8'h3C held -> busy rises, db_sw=8'h3C after exactly 18 edges, one db_tick, busy falls.
REQ-026 Bounce: sw toggles 8'h01/8'h00 every 5 cycles for 40 cycles, then holds 8'h01 -> no db_tick during the toggling; db_sw=8'h01 16 edges after the final settle starts.
REQ-027 Bounce-back: db_sw=8'h00, sw pulses 8'h80 for 6 cycles then returns to 8'h00 -> busy pulses, db_sw stays 8'h00, no db_tick.
REQ-028 Reset mid-SETTLE: sw=8'hFF, reset asserted on the 8th settle cycle -> db_sw=8'h00, busy=0, no db_tick; after release, db_sw=8'hFF once 18 edges have elapsed.
REQ-029 Macro undefined: repeat REQ-025 -> db_sw updates after 16 edges.
